mem_access_ctrl: RTL

Memory access controller between the LC-3b datapath (MAR/MDR, control-store MIO.EN/R.W/DATA.SIZE) and the two-bank byte-wide memory array. It latches each request, steers write data and the per-bank write enables we1/we0, and models a fixed multi-cycle memory latency. It returns the ready signal R and a captured read word for MDR.

---
 rtl/lc3b_mem_pkg.sv | 13 +
 rtl/mem_access_ctrl_wr_steer.sv | 26 ++
 rtl/mem_access_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/lc3b_mem_pkg.sv
// Shared types and sizing for the LC-3b memory access controller.
package lc3b_mem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;
    // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
    localparam int CNT_WIDTH  = 4;
endpackage

// File: rtl/mem_access_ctrl_wr_steer.sv
// Write-data steering and per-bank write enables; purely combinational, enables only while wr_en.
module mem_wr_steer #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  wr_en,
    input  logic                  data_size,
    input  logic                  addr_lsb,
    input  logic [WORD_WIDTH-1:0] mdr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  we1,
    output logic                  we0
);
    import lc3b_mem_pkg::*;

    always_comb begin
        mem_wdata = mdr;
        we1       = wr_en;
        we0       = wr_en;
        if (!data_size) begin
            // Byte stores put the byte on both lanes; the address LSB picks the bank.
            mem_wdata = {(WORD_WIDTH/BYTE_WIDTH){mdr[BYTE_WIDTH-1:0]}};
            we1       = wr_en & addr_lsb;
            we0       = wr_en & ~addr_lsb;
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory access controller: latches a request, waits MEM_LATENCY cycles, pulses r for one cycle.
// Optional MEM_UNALIGNED_TRAP_EN: unaligned word accesses complete at once with unaligned=1 and no side effects.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WORD_WIDTH  = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mio_en,
    input  logic                  r_w,
    input  logic                  data_size,
    input  logic [ADDR_WIDTH-1:0] mar,
    input  logic [WORD_WIDTH-1:0] mdr,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  we1,
    output logic                  we0,
    output logic                  r,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  unaligned
);
    import lc3b_mem_pkg::*;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_WIDTH-1:0]  mdr_q;
    logic                   wr_q;
    logic                   word_q;
    logic                   unal_q;
    logic                   trap_now;

`ifdef MEM_UNALIGNED_TRAP_EN
    assign trap_now  = data_size & mar[0];
    assign unaligned = (state == READY) & unal_q;
`else
    assign trap_now  = 1'b0;
    assign unaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            mdr_q  <= '0;
            wr_q   <= 1'b0;
            word_q <= 1'b0;
            unal_q <= 1'b0;
            rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mio_en) begin
                        // Word accesses always address an even byte pair.
                        addr_q <= {mar[ADDR_WIDTH-1:1], mar[0] & ~data_size};
                        mdr_q  <= mdr;
                        wr_q   <= r_w;
                        word_q <= data_size;
                        unal_q <= trap_now;
                        cnt    <= CNT_WIDTH'(MEM_LATENCY - 1);
                        state  <= (MEM_LATENCY == 1 || trap_now) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1))
                        state <= READY;
                end
                READY: begin
                    if (!wr_q && !unal_q)
                        rdata <= mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign r        = (state == READY);
    assign mem_addr = addr_q;

    mem_wr_steer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_wr_steer (
        .wr_en     ((state == READY) & wr_q & ~unal_q),
        .data_size (word_q),
        .addr_lsb  (addr_q[0]),
        .mdr       (mdr_q),
        .mem_wdata (mem_wdata),
        .we1       (we1),
        .we0       (we0)
    );
endmodule
